// File: rtl/ecc_point_index11.sv
// Reverse lookup of the p=11 curve point table (y^2 = x^3 + x + 2), (0,0) = infinity.
// Define ECC11_ONCURVE_CHECK_EN to add a two-cycle on-curve pre-check before the table scan.
module ecc_point_index11 #(
    parameter int EARLY_EXIT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [4:0] x,
    input  logic [4:0] y,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] idx,
    output logic       found
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
`ifdef ECC11_ONCURVE_CHECK_EN
        , CHECK
`endif
    } state_t;

    localparam bit EARLY = (EARLY_EXIT != 0);

    state_t     state;
    logic [4:0] xr;
    logic [4:0] yr;
    logic [3:0] cnt;
    logic       hit;
    logic [3:0] hit_idx;
    logic [4:0] tab_x;
    logic [4:0] tab_y;
    logic       match;
    logic       in_range;
    logic       scan_exit;

    always_comb begin
        tab_x = 5'd0;
        tab_y = 5'd0;
        case (cnt)
            4'd0:  begin tab_x = 5'd0;  tab_y = 5'd0;  end
            4'd1:  begin tab_x = 5'd5;  tab_y = 5'd0;  end
            4'd2:  begin tab_x = 5'd7;  tab_y = 5'd0;  end
            4'd3:  begin tab_x = 5'd10; tab_y = 5'd0;  end
            4'd4:  begin tab_x = 5'd2;  tab_y = 5'd1;  end
            4'd5:  begin tab_x = 5'd1;  tab_y = 5'd2;  end
            4'd6:  begin tab_x = 5'd4;  tab_y = 5'd2;  end
            4'd7:  begin tab_x = 5'd6;  tab_y = 5'd2;  end
            4'd8:  begin tab_x = 5'd8;  tab_y = 5'd4;  end
            4'd9:  begin tab_x = 5'd9;  tab_y = 5'd5;  end
            4'd10: begin tab_x = 5'd9;  tab_y = 5'd6;  end
            4'd11: begin tab_x = 5'd8;  tab_y = 5'd7;  end
            4'd12: begin tab_x = 5'd1;  tab_y = 5'd9;  end
            4'd13: begin tab_x = 5'd4;  tab_y = 5'd9;  end
            4'd14: begin tab_x = 5'd6;  tab_y = 5'd9;  end
            default: begin tab_x = 5'd2; tab_y = 5'd10; end
        endcase
    end

    assign match     = (tab_x == xr) && (tab_y == yr);
    assign in_range  = (x <= 5'd10) && (y <= 5'd10);
    // With EARLY_EXIT=0 the scan always runs to entry 15; hit/hit_idx keep the first match.
    assign scan_exit = (EARLY && match) || (cnt == 4'd15);

`ifdef ECC11_ONCURVE_CHECK_EN
    logic       phase;
    logic [6:0] xsq;
    logic [6:0] ysq;
    logic [6:0] xsq_next;
    logic [6:0] ysq_next;
    logic [6:0] rhs;

    always_comb begin
        xsq_next = ({2'b00, xr} * {2'b00, xr}) % 7'd11;
        ysq_next = ({2'b00, yr} * {2'b00, yr}) % 7'd11;
        rhs      = (xsq * {2'b00, xr} + {2'b00, xr} + 7'd2) % 7'd11;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            xr        <= 5'd0;
            yr        <= 5'd0;
            cnt       <= 4'd0;
            hit       <= 1'b0;
            hit_idx   <= 4'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            idx       <= 4'd0;
            found     <= 1'b0;
`ifdef ECC11_ONCURVE_CHECK_EN
            phase     <= 1'b0;
            xsq       <= 7'd0;
            ysq       <= 7'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        xr       <= x;
                        yr       <= y;
                        cnt      <= 4'd0;
                        hit      <= 1'b0;
                        hit_idx  <= 4'd0;
                        in_ready <= 1'b0;
                        if (!in_range) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            idx       <= 4'd0;
                            found     <= 1'b0;
                        end
`ifdef ECC11_ONCURVE_CHECK_EN
                        else if ((x != 5'd0) || (y != 5'd0)) begin
                            state <= CHECK;
                            phase <= 1'b0;
                        end
`endif
                        else begin
                            state <= SCAN;
                        end
                    end
                end
`ifdef ECC11_ONCURVE_CHECK_EN
                CHECK: begin
                    if (!phase) begin
                        xsq   <= xsq_next;
                        ysq   <= ysq_next;
                        phase <= 1'b1;
                    end else if (rhs == ysq) begin
                        state <= SCAN;
                    end else begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        idx       <= 4'd0;
                        found     <= 1'b0;
                    end
                end
`endif
                SCAN: begin
                    if (match && !hit) begin
                        hit     <= 1'b1;
                        hit_idx <= cnt;
                    end
                    if (scan_exit) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        found     <= hit || match;
                        idx       <= hit ? hit_idx : (match ? cnt : 4'd0);
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_point_index11.sv
// Directed bench for ecc_point_index11: one EARLY_EXIT=1 and one EARLY_EXIT=0 instance.
// Expected latencies follow ECC11_ONCURVE_CHECK_EN when the bench is built with it.
module tb_ecc_point_index11;

`ifdef ECC11_ONCURVE_CHECK_EN
    localparam int CK     = 2;
    localparam int LAT_33 = 3;
`else
    localparam int CK     = 0;
    localparam int LAT_33 = 17;
`endif

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_valid0;
    logic [4:0] x;
    logic [4:0] y;
    logic       out_ready;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] idx;
    logic       found;
    logic       in_ready0;
    logic       out_valid0;
    logic [3:0] idx0;
    logic       found0;

    int vectors;
    int miscompares;
    int seenValid;

    ecc_point_index11 #(.EARLY_EXIT(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
        .idx(idx), .found(found)
    );

    ecc_point_index11 #(.EARLY_EXIT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .x(x), .y(y), .out_valid(out_valid0), .out_ready(out_ready),
        .idx(idx0), .found(found0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Offer one point on the next clock edge; returns at the negedge of cycle 1.
    task automatic applyStimulus(input bit sel, input logic [4:0] px, input logic [4:0] py);
        @(negedge clk);
        checkOutput("in_ready before accept", sel ? in_ready0 : in_ready, 1);
        x = px;
        y = py;
        if (sel) in_valid0 = 1'b1;
        else     in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        in_valid0 = 1'b0;
    endtask

    task automatic awaitResult(input bit sel, input string tag, input int expCycle,
                               input logic [3:0] expIdx, input logic expFound);
        int cyc = 1;
        while (!(sel ? out_valid0 : out_valid) && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput({tag, " latency"}, cyc, expCycle);
        checkOutput({tag, " idx"}, sel ? idx0 : idx, expIdx);
        checkOutput({tag, " found"}, sel ? found0 : found, expFound);
    endtask

    task automatic completeHandshake(input bit sel);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("out_valid after handshake", sel ? out_valid0 : out_valid, 0);
        checkOutput("in_ready after handshake", sel ? in_ready0 : in_ready, 1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_valid0   = 1'b0;
        x           = 5'd0;
        y           = 5'd0;
        out_ready   = 1'b0;

        #12;
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset idx", idx, 0);
        checkOutput("reset found", found, 0);
        checkOutput("reset out_valid0", out_valid0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("in_ready after reset", in_ready, 1);
        checkOutput("in_ready0 after reset", in_ready0, 1);

        applyStimulus(0, 5'd9, 5'd6);
        awaitResult(0, "(9,6)", 12 + CK, 4'd10, 1'b1);
        completeHandshake(0);

        applyStimulus(0, 5'd0, 5'd0);
        awaitResult(0, "(0,0)", 2, 4'd0, 1'b1);
        completeHandshake(0);

        applyStimulus(0, 5'd3, 5'd3);
        awaitResult(0, "(3,3)", LAT_33, 4'd0, 1'b0);
        completeHandshake(0);

        applyStimulus(0, 5'd11, 5'd2);
        awaitResult(0, "(11,2)", 1, 4'd0, 1'b0);
        completeHandshake(0);

        applyStimulus(1, 5'd2, 5'd10);
        awaitResult(1, "EE0 (2,10)", 17 + CK, 4'd15, 1'b1);
        completeHandshake(1);

        applyStimulus(1, 5'd0, 5'd0);
        awaitResult(1, "EE0 (0,0)", 17, 4'd0, 1'b1);
        completeHandshake(1);

        // Result held under back-pressure while a new point is offered and must be ignored.
        applyStimulus(0, 5'd8, 5'd7);
        awaitResult(0, "(8,7)", 13 + CK, 4'd11, 1'b1);
        x        = 5'd5;
        y        = 5'd0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("hold out_valid", out_valid, 1);
            checkOutput("hold idx", idx, 11);
            checkOutput("hold found", found, 1);
            checkOutput("hold in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("handshake out_valid", out_valid, 0);
        checkOutput("no accept on handshake edge", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("(5,0) accepted after handshake", in_ready, 0);
        awaitResult(0, "(5,0) after hold", 3 + CK, 4'd1, 1'b1);
        completeHandshake(0);

        // Asynchronous reset in the middle of a scan discards the point.
        applyStimulus(0, 5'd6, 5'd9);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid-scan reset out_valid", out_valid, 0);
        checkOutput("mid-scan reset idx", idx, 0);
        checkOutput("mid-scan reset found", found, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("in_ready after mid-scan reset", in_ready, 1);
        seenValid = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) seenValid++;
        end
        checkOutput("no out_valid for discarded point", seenValid, 0);

        applyStimulus(0, 5'd5, 5'd0);
        awaitResult(0, "(5,0) after reset", 3 + CK, 4'd1, 1'b1);
        completeHandshake(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
